// File: rtl/bcd_conv_scheduler_if.sv
// Bus bundle between the shared bin2bcd scheduler and the rest of the clock:
// per-channel requests/operands in, shared converter operand/result, and
// per-channel BCD results out to the display mux.
interface bcd_conv_scheduler_if #(
    parameter int NUM_CH = 3,
    parameter int BIN_W  = 8,
    parameter int BCD_W  = 12
);
    logic [NUM_CH-1:0]       i_req;
    logic [NUM_CH*BIN_W-1:0] i_bin;
    logic [BIN_W-1:0]        conv_bin;
    logic [BCD_W-1:0]        conv_bcd;
    logic [NUM_CH*BCD_W-1:0] o_bcd;
    logic [NUM_CH-1:0]       o_valid;
    logic                    o_busy;

    // System side: requesters plus the shared converter result.
    modport master (
        output i_req, i_bin, conv_bcd,
        input  conv_bin, o_bcd, o_valid, o_busy
    );

    // Scheduler side.
    modport slave (
        input  i_req, i_bin, conv_bcd,
        output conv_bin, o_bcd, o_valid, o_busy
    );
endinterface

// File: rtl/bcd_conv_scheduler.sv
// Time-shares one sequential bin2bcd converter among NUM_CH requesters.
// Requests are latched into a pending vector, arbitrated round-robin, the
// granted operand is snapshotted onto conv_bin, and after a fixed latency
// the converter result is stored in that channel's output slot.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no conversion in flight; grant next pending channel if any
// WAIT    | conv_bin held, counting down the converter latency
// CAPTURE | conv_bcd valid; store it into the granted slot, pulse o_valid
module bcd_conv_scheduler #(
    parameter int NUM_CH       = 3,
    parameter int BIN_W        = 8,
    parameter int BCD_W        = 12,
    parameter int CONV_LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    bcd_conv_scheduler_if.slave bus
);
    localparam int GNT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (CONV_LATENCY > 1) ? $clog2(CONV_LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_CH-1:0]       pend_q, pend_d;
    logic [GNT_W-1:0]        last_grant_q;
    logic [GNT_W-1:0]        gnt_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [BIN_W-1:0]        conv_bin_q;
    logic [NUM_CH*BCD_W-1:0] o_bcd_q;
    logic [NUM_CH-1:0]       o_valid_q;
    logic                    o_busy_q;

    logic [GNT_W-1:0]        sel;
    logic                    sel_found;
    logic                    grant_en;
    logic                    capture_en;

    // Round-robin pick: first pending channel after the last one granted.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            logic [GNT_W-1:0] idx;
            idx = GNT_W'((int'(last_grant_q) + i) % NUM_CH);
            if (!sel_found && pend_q[idx]) begin
                sel_found = 1'b1;
                sel       = idx;
            end
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_d    = state_q;
        grant_en   = 1'b0;
        capture_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    grant_en = 1'b1;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                capture_en = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pending set: new requests OR in; the captured channel drops out unless
    // it is being requested again on the same edge.
    always_comb begin
        pend_d = pend_q | bus.i_req;
        if (capture_en) begin
            pend_d[gnt_q] = bus.i_req[gnt_q];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: grant snapshot, latency countdown, result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q       <= '0;
            last_grant_q <= GNT_W'(NUM_CH - 1);
            gnt_q        <= '0;
            cnt_q        <= '0;
            conv_bin_q   <= '0;
            o_bcd_q      <= '0;
            o_valid_q    <= '0;
            o_busy_q     <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            o_valid_q <= '0;
            o_busy_q  <= (state_d != S_IDLE);
            if (grant_en) begin
                gnt_q        <= sel;
                last_grant_q <= sel;
                conv_bin_q   <= bus.i_bin[sel*BIN_W +: BIN_W];
                cnt_q        <= CNT_W'(CONV_LATENCY - 1);
            end else if (state_q == S_WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (capture_en) begin
                o_bcd_q[gnt_q*BCD_W +: BCD_W] <= bus.conv_bcd;
                o_valid_q[gnt_q]              <= 1'b1;
            end
        end
    end

    assign bus.conv_bin = conv_bin_q;
    assign bus.o_bcd    = o_bcd_q;
    assign bus.o_valid  = o_valid_q;
    assign bus.o_busy   = o_busy_q;

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Bench for bcd_conv_scheduler: directed scenarios followed by random request
// batches, checked against a transaction-level model (round-robin order over
// the pending set, fixed 4-cycle request-to-result spacing, decimal digits).
module tb_bcd_conv_scheduler;
    localparam int NUM_CH = 3;
    localparam int BIN_W  = 8;
    localparam int BCD_W  = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bcd_conv_scheduler_if #(.NUM_CH(NUM_CH), .BIN_W(BIN_W), .BCD_W(BCD_W)) bus ();

    bcd_conv_scheduler #(
        .NUM_CH(NUM_CH), .BIN_W(BIN_W), .BCD_W(BCD_W), .CONV_LATENCY(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [11:0] to_bcd(input logic [7:0] v);
        int x;
        x = int'(v);
        return {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
    endfunction

    // Shared converter model: result valid two edges after conv_bin changes.
    logic [11:0] cv1, cv2;
    always @(posedge clk) begin
        cv1 <= to_bcd(bus.conv_bin);
        cv2 <= cv1;
    end
    assign bus.conv_bcd = cv2;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] exp_slot [NUM_CH];
    int          last_g;

    function automatic logic [35:0] exp_bcd();
        logic [35:0] r;
        for (int c = 0; c < NUM_CH; c++) r[c*12 +: 12] = exp_slot[c];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_bin(input int ch, input logic [7:0] v);
        bus.i_bin[ch*8 +: 8] = v;
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) exp_slot[c] = '0;
        last_g = NUM_CH - 1;
    endtask

    // Expect channel ch to deliver value v on the n-th cycle from now,
    // with o_valid quiet before that and busy through the conversion.
    task automatic wait_valid(input string tag, input int ch, input logic [7:0] v, input int n);
        for (int i = 1; i < n; i++) begin
            step();
            check({tag, "_quiet"}, 64'(bus.o_valid), 64'(0));
            if (i == 1) check({tag, "_busy"}, 64'(bus.o_busy), 64'(1));
        end
        step();
        exp_slot[ch] = to_bcd(v);
        last_g = ch;
        check({tag, "_valid"}, 64'(bus.o_valid), 64'(1 << ch));
        check({tag, "_obcd"}, 64'(bus.o_bcd), 64'(exp_bcd()));
        check({tag, "_idle"}, 64'(bus.o_busy), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v [NUM_CH];
        logic [7:0] rv;
        logic [2:0] mask;
        int         order [$];

        model_reset();
        rst       = 1'b1;
        bus.i_req = '0;
        bus.i_bin = '0;

        // 1: reset held with all requests asserted
        bus.i_req = 3'b111;
        repeat (3) step();
        check("rst_valid", 64'(bus.o_valid), 64'(0));
        check("rst_obcd", 64'(bus.o_bcd), 64'(0));
        check("rst_busy", 64'(bus.o_busy), 64'(0));
        check("rst_convbin", 64'(bus.conv_bin), 64'(0));
        for (int c = 0; c < NUM_CH; c++) begin
            v[c] = 8'($urandom_range(0, 255));
            set_bin(c, v[c]);
        end
        rst = 1'b0;
        step();
        bus.i_req = '0;
        check("rel_busy", 64'(bus.o_busy), 64'(0));
        wait_valid("rel_ch0", 0, v[0], 4);
        wait_valid("rel_ch1", 1, v[1], 4);
        wait_valid("rel_ch2", 2, v[2], 4);

        // 3: round-robin with fixed values
        set_bin(0, 8'd23); set_bin(1, 8'd45); set_bin(2, 8'd255);
        bus.i_req = 3'b111;
        step();
        bus.i_req = '0;
        wait_valid("rr_ch0", 0, 8'd23, 4);
        wait_valid("rr_ch1", 1, 8'd45, 4);
        wait_valid("rr_ch2", 2, 8'd255, 4);
        check("rr_hex", 64'(bus.o_bcd), 64'(36'h255_045_023));

        // 2: single request on ch1
        set_bin(1, 8'd59);
        bus.i_req = 3'b010;
        step();
        bus.i_req = '0;
        step();
        check("single_convbin", 64'(bus.conv_bin), 64'(59));
        check("single_busy", 64'(bus.o_busy), 64'(1));
        wait_valid("single", 1, 8'd59, 3);
        check("single_slot", 64'(bus.o_bcd[23:12]), 64'(12'h059));
        step();
        check("single_pulse", 64'(bus.o_valid), 64'(0));

        // 4: operand snapshot at grant
        set_bin(0, 8'd10);
        bus.i_req = 3'b001;
        step();
        bus.i_req = '0;
        step();
        set_bin(0, 8'd64);
        wait_valid("snap_old", 0, 8'd10, 3);
        check("snap_old_hex", 64'(bus.o_bcd[11:0]), 64'(12'h010));
        bus.i_req = 3'b001;
        step();
        bus.i_req = '0;
        wait_valid("snap_new", 0, 8'd64, 4);
        check("snap_new_hex", 64'(bus.o_bcd[11:0]), 64'(12'h064));

        // 5: re-request during the capture cycle of ch2
        rv = 8'($urandom_range(0, 255));
        set_bin(2, rv);
        bus.i_req = 3'b100;
        step();
        bus.i_req = '0;
        repeat (3) begin
            step();
            check("rereq_quiet", 64'(bus.o_valid), 64'(0));
        end
        bus.i_req = 3'b100;
        step();
        bus.i_req = '0;
        exp_slot[2] = to_bcd(rv);
        last_g = 2;
        check("rereq_first", 64'(bus.o_valid), 64'(3'b100));
        check("rereq_first_obcd", 64'(bus.o_bcd), 64'(exp_bcd()));
        wait_valid("rereq_second", 2, rv, 4);
        repeat (5) begin
            step();
            check("rereq_done", 64'(bus.o_valid), 64'(0));
        end

        // 6: reset during WAIT of ch1
        rv = 8'($urandom_range(0, 255));
        set_bin(1, rv);
        bus.i_req = 3'b010;
        step();
        bus.i_req = '0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        check("midrst_valid", 64'(bus.o_valid), 64'(0));
        check("midrst_obcd", 64'(bus.o_bcd), 64'(0));
        check("midrst_busy", 64'(bus.o_busy), 64'(0));
        repeat (4) begin
            step();
            check("midrst_quiet", 64'(bus.o_valid), 64'(0));
        end
        bus.i_req = 3'b010;
        step();
        bus.i_req = '0;
        wait_valid("midrst_next", 1, rv, 4);

        // Random batches against the round-robin model
        for (int it = 0; it < 25; it++) begin
            mask = 3'($urandom_range(1, 7));
            for (int c = 0; c < NUM_CH; c++) begin
                v[c] = 8'($urandom_range(0, 255));
                set_bin(c, v[c]);
            end
            repeat ($urandom_range(0, 2)) begin
                step();
                check("rnd_gap", 64'(bus.o_valid), 64'(0));
            end
            order.delete();
            for (int i = 1; i <= NUM_CH; i++) begin
                int c;
                c = (last_g + i) % NUM_CH;
                if (mask[c]) order.push_back(c);
            end
            bus.i_req = mask;
            step();
            bus.i_req = '0;
            foreach (order[k]) wait_valid("rnd", order[k], v[order[k]], 4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
